// File: rtl/sum_accum_pkg.sv
// ============================================================================
// Module : sum_accum_pkg
// Brief  : Shared state encoding and default widths for the frame accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sum_accum_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ACC_W  = 40;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sum_accum.sv
// ============================================================================
// Module : sum_accum
// Brief  : Accumulates FRAME_LEN signed sums per frame; holds total + overflow
//          flag on a valid/ready output until it is accepted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ACC_W     = DEFAULT_ACC_W,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic              out_ovf
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   total_q, total_d;
  logic               out_ovf_q, out_ovf_d;

  logic signed [DATA_W-1:0] in_sum_s;
  logic [ACC_W-1:0]         sum_ext;
  logic [ACC_W-1:0]         sum_next;
  logic                     samp_ovf;
  logic                     accept;

  assign in_sum_s = in_sum;
  assign sum_ext  = ACC_W'(in_sum_s);
  assign sum_next = acc_q + sum_ext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign samp_ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                    (sum_next[ACC_W-1] != acc_q[ACC_W-1]);

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_total = total_q;
  assign out_ovf   = out_ovf_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    total_d   = total_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      ACC: begin
        if (accept) begin
          if (cnt_q == C_LAST) begin
            state_d   = OUT;
            total_d   = sum_next;
            out_ovf_d = ovf_q | samp_ovf;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | samp_ovf;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    // Abort wins over any handshake in the same cycle; the held total is kept
    // but no longer presented.
    if (clear) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      total_q   <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      total_q   <= total_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sum_accum.sv
// ============================================================================
// Module : tb_sum_accum
// Brief  : Scoreboard bench driving a 40-bit and a 32-bit accumulator in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sum_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_sum;
  logic        clear;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [39:0] out_total_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [31:0] out_total_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [40:0] q_a[$];
  logic [32:0] q_b[$];

  always #5 clk = ~clk;

  sum_accum #(.DATA_W(32), .ACC_W(40), .FRAME_LEN(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .clear(clear), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_total(out_total_a), .out_ovf(out_ovf_a)
  );

  sum_accum #(.DATA_W(32), .ACC_W(32), .FRAME_LEN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .clear(clear), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_total(out_total_b), .out_ovf(out_ovf_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected frames are queued for both widths when the frame is issued.
  task automatic expect_frame(input logic [39:0] tot_a, input logic ovf_a,
                              input logic [31:0] tot_b, input logic ovf_b);
    q_a.push_back({ovf_a, tot_a});
    q_b.push_back({ovf_b, tot_b});
  endtask

  task automatic send(input logic [31:0] v);
    bit done = 0;
    in_sum   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_sum   = 'x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (q_a.size() == 0) chk("unexpected_frame_a", {23'd0, out_ovf_a, out_total_a}, 64'd0);
      else chk("frame_a", {23'd0, out_ovf_a, out_total_a}, {23'd0, q_a.pop_front()});
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (q_b.size() == 0) chk("unexpected_frame_b", {31'd0, out_ovf_b, out_total_b}, 64'd0);
      else chk("frame_b", {31'd0, out_ovf_b, out_total_b}, {31'd0, q_b.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state_a", {out_valid_a, out_ovf_a, in_ready_a, out_total_a}, {3'b001, 40'd0});
    chk("reset_state_b", {out_valid_b, out_ovf_b, in_ready_b, 8'd0, out_total_b}, {3'b001, 40'd0});

    // Basic frame with one-cycle output latency.
    expect_frame(40'd340, 1'b0, 32'd340, 1'b0);
    send(32'd15); send(32'd155); send(32'd115);
    chk("no_early_valid", {63'd0, out_valid_a}, 64'd0);
    send(32'd55);
    chk("valid_after_last", {63'd0, out_valid_a}, 64'd1);
    chk("ready_low_in_out", {63'd0, in_ready_a}, 64'd0);
    tick();
    chk("ready_after_take", {62'd0, in_ready_a, out_valid_a}, 64'd2);

    // Backpressure: frame held for five cycles.
    out_ready = 1'b0;
    expect_frame(40'd340, 1'b0, 32'd340, 1'b0);
    send(32'd15); send(32'd155); send(32'd115); send(32'd55);
    for (int i = 0; i < 5; i++) begin
      chk("hold_total", {24'd0, out_total_a}, 64'd340);
      chk("hold_ready", {62'd0, in_ready_a, out_valid_a}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("ready_after_backpressure", {63'd0, in_ready_a}, 64'd1);

    // Gaps in the input stream are not counted.
    expect_frame(40'd0, 1'b0, 32'd0, 1'b0);
    send(-32'sd7); send(32'd3);
    tick(); tick();
    send(-32'sd1); send(32'd5);
    tick();

    // Overflow only on the 32-bit accumulator; flag is per frame.
    expect_frame(40'h00_8000_0000, 1'b0, 32'h8000_0000, 1'b1);
    send(32'h7FFF_FFFF); send(32'd1); send(32'd0); send(32'd0);
    tick();
    expect_frame(40'd4, 1'b0, 32'd4, 1'b0);
    send(32'd1); send(32'd1); send(32'd1); send(32'd1);
    tick();

    // Clear mid-frame drops partial sum and the sample offered alongside it.
    send(32'd10); send(32'd20);
    in_valid = 1'b1; in_sum = 32'd99; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    expect_frame(40'd10, 1'b0, 32'd10, 1'b0);
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    tick();

    // Clear while a frame is pending discards it.
    out_ready = 1'b0;
    send(32'd5); send(32'd6); send(32'd7); send(32'd8);
    chk("pending_before_clear", {63'd0, out_valid_a}, 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_drops_valid", {62'd0, out_valid_a, in_ready_a}, 64'd1);
    out_ready = 1'b1;

    // Reset mid-frame.
    send(32'd1); send(32'd2); send(32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midframe_reset_a", {out_valid_a, out_ovf_a, in_ready_a, out_total_a}, {3'b001, 40'd0});
    chk("midframe_reset_b", {out_valid_b, out_ovf_b, in_ready_b, 8'd0, out_total_b}, {3'b001, 40'd0});
    expect_frame(40'd22, 1'b0, 32'd22, 1'b0);
    send(32'd4); send(32'd5); send(32'd6); send(32'd7);
    tick(); tick();

    chk("frames_drained_a", 64'(q_a.size()), 64'd0);
    chk("frames_drained_b", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
